pulser_config: RTL and testbench
================================

// Module: pulser_config
// PURPOSE
//  Upstream config stage for pulser. Parses byte frames from the UART receiver into six
//  shadow timing registers, then commits them atomically to the active set that drives
//  pulser, at a laser-period boundary. Also owns run enable (drives pulser's reset) and
//  returns a 1-byte ACK/NAK to the UART transmitter.
// PARAMETERS
//  N_BITS          20      width of each timing value; must be <= 24
//  TIMEOUT_CYCLES  120000  max clk cycles between bytes of one frame (10 ms @ 12 MHz)
// PORTS
//  clk             in   1       system clock
//  reset_n         in   1       asynchronous, active-low reset
//  rx_data         in   8       received byte
//  rx_valid        in   1       1-cycle strobe, rx_data valid
//  tx_data         out  8       response byte (0x06 ACK, 0x15 NAK)
//  tx_valid        out  1       response valid; held until tx_ready
//  tx_ready        in   1       transmitter accepts tx_data when tx_valid&tx_ready
//  cycle_boundary  in   1       1-cycle pulse at pulser count wrap (count==0)
//  repeat_period, pulse_length, warm_up_time, delay, pre_exposure, exposure_time
//                  out  N_BITS  active timing values to pulser
//  pulser_reset    out  1       active-high reset to pulser; 1 when run disabled
//  err_count       out  8       saturating count of rejected frames/dropped responses
// BEHAVIOUR
//  Reset (reset_n=0, async): all shadow/active regs 0, run=0, pulser_reset=1, tx_valid=0,
//   tx_data=0, err_count=0, commit_pending=0, parser IDLE.
//  Frame: 0xA5, ADDR, D2, D1, D0, CHK; CHK = ADDR^D2^D1^D0; value = {D2,D1,D0}.
//  Parser FSM: IDLE -(0xA5)-> ADDR -> D2 -> D1 -> D0 -> CHK -> back to IDLE.
//   In IDLE, non-0xA5 bytes are discarded silently. Once past IDLE, the inter-byte timer
//   reloads on each byte. At TIMEOUT_CYCLES with no byte: go to IDLE, err_count+1, no response.
//  Frame execution happens in the cycle after the CHK byte:
//   ADDR 0..5: write shadow reg (0 repeat_period, 1 pulse_length, 2 warm_up_time,
//    3 delay, 4 pre_exposure, 5 exposure_time) -> ACK.
//   ADDR 0x10 commit: NAK if shadow repeat_period==0; else commit_pending=1, ACK.
//   ADDR 0x11 run: run = D0[0]; pulser_reset = ~run the cycle after execution; ACK.
//   NAK (no state change, err_count+1) on: bad CHK, unknown ADDR,
//    or value bits [23:N_BITS] nonzero.
//  Commit: active<=shadow (all six in one cycle) and commit_pending<=0 when commit_pending
//   is set and either (cycle_boundary=1) or (run=0). Latency with run=0 is 1 cycle after
//   commit_pending is set. Outputs never show a partial update.
//   Shadow write and commit in the same cycle: active takes the pre-write shadow value.
//   A commit while commit_pending is already set: ACK, stays pending (idempotent).
//  Response: 1-deep. tx_valid rises the cycle after frame execution and drops the cycle
//   after the tx_valid&tx_ready handshake. If a new response arrives while tx_valid=1,
//   the new response is dropped, err_count+1, and the frame's side-effects still apply.
//  err_count saturates at 255. Parser keeps accepting rx bytes regardless of tx state.
//  A reset mid-frame or mid-pending discards everything; after reset, all regs are 0
//   and pulser is held in reset.
// STRUCTURE
//  Package pewpew_cfg_pkg: frame constants (SOF=0xA5, ACK=0x06, NAK=0x15),
//   address constants (ADDR_REPEAT..ADDR_EXPOSURE, ADDR_COMMIT, ADDR_RUN),
//   parser state encoding.
//  Sub-module cfg_frame_parser: FSM + timeout + checksum. Outputs frame_done,
//   frame_ok, addr[7:0], value[23:0]. pulser_config holds the register banks,
//   commit logic and response logic.
// TESTING
//  1 Reset; write ADDR0=1000, commit, run=1 -> three ACKs; repeat_period=1000 with run=0
//    before run; pulser_reset=0 after the run frame.
//  2 run=1; write ADDR1=50 and commit; no cycle_boundary -> pulse_length stays old;
//    pulse cycle_boundary -> pulse_length=50 next cycle, all six change in the same cycle.
//  3 Corrupt CHK (frame A5 01 00 00 32 00) -> NAK, err_count=1, shadow unchanged.
//  4 ADDR0 with value 0x100000 (N_BITS=20) -> NAK; commit with shadow repeat=0 -> NAK.
//  5 Send 3 bytes of a frame, then idle TIMEOUT_CYCLES -> err_count+1, no tx;
//    next full valid frame -> ACK.
//  6 Hold tx_ready=0 over two frames -> first response stays valid, second dropped,
//    err_count+1; async reset mid-frame -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pewpew_cfg_pkg.sv
// rtl/pewpew_cfg_pkg.sv - shared constants and parser state encoding for pulser_config
// Purpose: frame marker, response codes, register addresses and the parser state enum.
// Ports: none (package).
package pewpew_cfg_pkg;

  localparam logic [7:0] SOF = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  localparam logic [7:0] ADDR_REPEAT   = 8'h00;
  localparam logic [7:0] ADDR_PULSE    = 8'h01;
  localparam logic [7:0] ADDR_WARM_UP  = 8'h02;
  localparam logic [7:0] ADDR_DELAY    = 8'h03;
  localparam logic [7:0] ADDR_PRE_EXP  = 8'h04;
  localparam logic [7:0] ADDR_EXPOSURE = 8'h05;
  localparam logic [7:0] ADDR_COMMIT   = 8'h10;
  localparam logic [7:0] ADDR_RUN      = 8'h11;

  localparam int N_REGS = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_D2,
    ST_D1,
    ST_D0,
    ST_CHK
  } parse_state_e;

endpackage

// File: rtl/cfg_frame_parser.sv
// rtl/cfg_frame_parser.sv - byte-frame parser with inter-byte timeout and checksum
// Purpose: assembles 0xA5,ADDR,D2,D1,D0,CHK frames from a byte stream.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   rx_data, rx_valid    incoming byte and its 1-cycle strobe
//   frame_done           1-cycle pulse the cycle after the CHK byte
//   frame_ok             checksum matched (valid with frame_done)
//   addr, value          frame address and 24-bit payload (valid with frame_done)
//   timeout              1-cycle pulse when a partial frame was abandoned
module cfg_frame_parser
  import pewpew_cfg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [7:0]  addr,
  output logic [23:0] value,
  output logic        timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  parse_state_e  state_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    chk_q;
  logic [7:0]    addr_q;
  logic [23:0]   value_q;
  logic          frame_done_q;
  logic          frame_ok_q;
  logic          timeout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      chk_q        <= '0;
      addr_q       <= '0;
      value_q      <= '0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      if (rx_valid) begin
        timer_q <= '0;
        case (state_q)
          ST_IDLE: if (rx_data == SOF) state_q <= ST_ADDR;
          ST_ADDR: begin
            addr_q  <= rx_data;
            chk_q   <= rx_data;
            state_q <= ST_D2;
          end
          ST_D2: begin
            value_q[23:16] <= rx_data;
            chk_q          <= chk_q ^ rx_data;
            state_q        <= ST_D1;
          end
          ST_D1: begin
            value_q[15:8] <= rx_data;
            chk_q         <= chk_q ^ rx_data;
            state_q       <= ST_D0;
          end
          ST_D0: begin
            value_q[7:0] <= rx_data;
            chk_q        <= chk_q ^ rx_data;
            state_q      <= ST_CHK;
          end
          ST_CHK: begin
            frame_done_q <= 1'b1;
            frame_ok_q   <= (rx_data == chk_q);
            state_q      <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE) begin
        // timer_q counts idle cycles since the last byte; the final idle cycle aborts.
        if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_q   <= ST_IDLE;
          timer_q   <= '0;
          timeout_q <= 1'b1;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end
    end
  end

  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign addr       = addr_q;
  assign value      = value_q;
  assign timeout    = timeout_q;

endmodule

// File: rtl/pulser_config.sv
// rtl/pulser_config.sv - config stage: shadow/active timing banks, commit, run, ACK/NAK
// Purpose: executes parsed frames, commits shadow->active atomically at a laser-period
//   boundary (or at once while stopped), drives pulser reset, returns a response byte.
// Ports:
//   clk, reset_n               clock, async active-low reset
//   rx_data, rx_valid          received byte stream
//   tx_data, tx_valid, tx_ready  1-deep response (0x06 ACK / 0x15 NAK)
//   cycle_boundary             pulser count-wrap pulse
//   repeat_period .. exposure_time  active timing values
//   pulser_reset               high while run is disabled
//   err_count                  saturating count of rejected frames, timeouts, dropped responses
module pulser_config
  import pewpew_cfg_pkg::*;
#(
  parameter int N_BITS         = 20,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              cycle_boundary,
  output logic [N_BITS-1:0] repeat_period,
  output logic [N_BITS-1:0] pulse_length,
  output logic [N_BITS-1:0] warm_up_time,
  output logic [N_BITS-1:0] delay,
  output logic [N_BITS-1:0] pre_exposure,
  output logic [N_BITS-1:0] exposure_time,
  output logic              pulser_reset,
  output logic [7:0]        err_count
);

  logic        frm_done;
  logic        frm_ok;
  logic [7:0]  frm_addr;
  logic [23:0] frm_value;
  logic        frm_timeout;

  cfg_frame_parser #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_parser (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_done(frm_done),
    .frame_ok  (frm_ok),
    .addr      (frm_addr),
    .value     (frm_value),
    .timeout   (frm_timeout)
  );

  logic [N_BITS-1:0] shadow_q [N_REGS];
  logic [N_BITS-1:0] shadow_d [N_REGS];
  logic [N_BITS-1:0] active_q [N_REGS];
  logic [N_BITS-1:0] active_d [N_REGS];
  logic              pending_q, pending_d;
  logic              run_q, run_d;
  logic              pulser_reset_q, pulser_reset_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        err_q, err_d;

  logic              commit_fire;
  logic              range_ok;
  logic              accept;
  logic [1:0]        err_inc;
  logic [8:0]        err_sum;

  always_comb begin
    shadow_d       = shadow_q;
    active_d       = active_q;
    pending_d      = pending_q;
    run_d          = run_q;
    tx_valid_d     = tx_valid_q;
    tx_data_d      = tx_data_q;
    accept         = 1'b0;
    err_inc        = 2'd0;
    range_ok       = ((frm_value >> N_BITS) == 24'd0);

    // While stopped there are no boundaries to wait for, so commit straight away.
    // Active takes shadow_q, i.e. the value before any write executing this cycle.
    commit_fire = pending_q && (cycle_boundary || !run_q);
    if (commit_fire) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;

    if (frm_done) begin
      if (frm_ok && range_ok) begin
        case (frm_addr)
          ADDR_REPEAT, ADDR_PULSE, ADDR_WARM_UP, ADDR_DELAY, ADDR_PRE_EXP, ADDR_EXPOSURE: begin
            shadow_d[frm_addr[2:0]] = frm_value[N_BITS-1:0];
            accept = 1'b1;
          end
          ADDR_COMMIT: begin
            if (shadow_q[0] != '0) begin
              pending_d = 1'b1;
              accept    = 1'b1;
            end
          end
          ADDR_RUN: begin
            run_d  = frm_value[0];
            accept = 1'b1;
          end
          default: accept = 1'b0;
        endcase
      end
      if (!accept) err_inc = err_inc + 2'd1;
      // Only one response slot: a response arriving while one is still shown is lost.
      if (tx_valid_q) begin
        err_inc = err_inc + 2'd1;
      end else begin
        tx_valid_d = 1'b1;
        tx_data_d  = accept ? ACK : NAK;
      end
    end

    if (frm_timeout) err_inc = err_inc + 2'd1;

    err_sum        = {1'b0, err_q} + {7'd0, err_inc};
    err_d          = err_sum[8] ? 8'hFF : err_sum[7:0];
    pulser_reset_d = ~run_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pending_q      <= 1'b0;
      run_q          <= 1'b0;
      pulser_reset_q <= 1'b1;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      err_q          <= 8'h00;
    end else begin
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      run_q          <= run_d;
      pulser_reset_q <= pulser_reset_d;
      tx_valid_q     <= tx_valid_d;
      tx_data_q      <= tx_data_d;
      err_q          <= err_d;
    end
  end

  assign repeat_period = active_q[0];
  assign pulse_length  = active_q[1];
  assign warm_up_time  = active_q[2];
  assign delay         = active_q[3];
  assign pre_exposure  = active_q[4];
  assign exposure_time = active_q[5];
  assign pulser_reset  = pulser_reset_q;
  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_pulser_config.sv
// tb/tb_pulser_config.sv - self-checking bench for pulser_config against a frame-level model
module tb_pulser_config;

  localparam int NB = 20;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        cycle_boundary;
  logic [NB-1:0] repeat_period, pulse_length, warm_up_time, delay, pre_exposure, exposure_time;
  logic        pulser_reset;
  logic [7:0]  err_count;
  logic [NB-1:0] act [6];

  assign act[0] = repeat_period;
  assign act[1] = pulse_length;
  assign act[2] = warm_up_time;
  assign act[3] = delay;
  assign act[4] = pre_exposure;
  assign act[5] = exposure_time;

  always #5 clk = ~clk;

  pulser_config #(.N_BITS(NB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cycle_boundary(cycle_boundary),
    .repeat_period(repeat_period), .pulse_length(pulse_length),
    .warm_up_time(warm_up_time), .delay(delay), .pre_exposure(pre_exposure),
    .exposure_time(exposure_time), .pulser_reset(pulser_reset), .err_count(err_count)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  int m_shadow [6];
  int m_active [6];
  bit m_run;
  bit m_pending;
  int m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 6; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    m_run = 0; m_pending = 0; m_err = 0;
  endtask

  task automatic m_bump_err();
    m_err = (m_err >= 255) ? 255 : m_err + 1;
  endtask

  task automatic m_frame(input logic [7:0] a, input logic [23:0] v, input bit chk_ok,
                         input bit dropped, output logic [7:0] resp);
    bit ok;
    ok = chk_ok && (int'(v) < (1 << NB));
    if (ok) begin
      if (a <= 8'd5) m_shadow[a] = int'(v);
      else if (a == 8'h10) begin
        if (m_shadow[0] == 0) ok = 0;
        else m_pending = 1;
      end else if (a == 8'h11) m_run = v[0];
      else ok = 0;
    end
    if (!ok) m_bump_err();
    if (dropped) m_bump_err();
    resp = ok ? 8'h06 : 8'h15;
  endtask

  task automatic m_commit(input bit boundary);
    if (m_pending && (boundary || !m_run)) begin
      m_active  = m_shadow;
      m_pending = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_act%0d", tag, i), 32'(act[i]), 32'(m_active[i]));
    check({tag, "_prst"}, 32'(pulser_reset), 32'(!m_run));
    check({tag, "_err"}, 32'(err_count), 32'(m_err));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [23:0] v, input logic [7:0] cx);
    send_byte(8'hA5, 1);
    send_byte(a, 1);
    send_byte(v[23:16], 1);
    send_byte(v[15:8], 1);
    send_byte(v[7:0], 1);
    send_byte(a ^ v[23:16] ^ v[15:8] ^ v[7:0] ^ cx, 0);
  endtask

  task automatic wait_resp(input string tag, input logic [7:0] exp, output int lat);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (tx_valid) break;
    end
    check({tag, "_txv"}, 32'(tx_valid), 32'd1);
    check({tag, "_txd"}, 32'(tx_data), 32'(exp));
  endtask

  task automatic do_frame(input string tag, input logic [7:0] a, input logic [23:0] v,
                          input logic [7:0] cx, input bit dropped);
    logic [7:0] exp;
    int lat;
    send_frame(a, v, cx);
    m_frame(a, v, cx == 8'h00, dropped, exp);
    if (tx_ready) wait_resp(tag, exp, lat);
    repeat (2) @(negedge clk);
    m_commit(0);
    check_outputs(tag);
  endtask

  task automatic pulse_boundary();
    @(negedge clk);
    cycle_boundary = 1'b1;
    @(negedge clk);
    cycle_boundary = 1'b0;
    m_commit(1);
  endtask

  initial begin
    logic [7:0] exp;
    int lat;
    int cnt;
    logic [7:0] a;
    logic [23:0] v;
    logic [7:0] cx;
    int r;

    reset_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1; cycle_boundary = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check_outputs("rst");
    check("rst_txv", 32'(tx_valid), 32'd0);
    check("rst_txd", 32'(tx_data), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: write, commit while stopped, then run
    do_frame("t1_wr", 8'h00, 24'd1000, 8'h00, 0);
    send_frame(8'h10, 24'd0, 8'h00);
    m_frame(8'h10, 24'd0, 1, 0, exp);
    wait_resp("t1_cm", exp, lat);
    check("t1_cm_lat", 32'(lat), 32'd1);
    check("t1_cm_old", 32'(repeat_period), 32'd0);
    @(negedge clk);
    check("t1_cm_new", 32'(repeat_period), 32'd1000);
    check("t1_prst_stopped", 32'(pulser_reset), 32'd1);
    m_commit(0);
    do_frame("t1_run", 8'h11, 24'd1, 8'h00, 0);

    // 2: while running, a commit waits for the boundary and all registers move together
    do_frame("t2_w1", 8'h01, 24'd50, 8'h00, 0);
    do_frame("t2_w2", 8'h02, 24'd333, 8'h00, 0);
    do_frame("t2_w5", 8'h05, 24'd4444, 8'h00, 0);
    do_frame("t2_cm", 8'h10, 24'd0, 8'h00, 0);
    repeat (5) @(negedge clk);
    check_outputs("t2_hold");
    pulse_boundary();
    check("t2_pl", 32'(pulse_length), 32'd50);
    check_outputs("t2_after");

    // 3: corrupted checksum
    do_frame("t3_badchk", 8'h01, 24'h000032, 8'h33, 0);
    do_frame("t3_cm", 8'h10, 24'd0, 8'h00, 0);
    pulse_boundary();
    check_outputs("t3_shadow");

    // 4: out-of-range value, commit with zero repeat_period
    do_frame("t4_range", 8'h00, 24'h100000, 8'h00, 0);
    do_frame("t4_zero", 8'h00, 24'd0, 8'h00, 0);
    do_frame("t4_cmnak", 8'h10, 24'd0, 8'h00, 0);
    do_frame("t4_rest", 8'h00, 24'd1000, 8'h00, 0);

    // 5: partial frame abandoned by the inter-byte timeout
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 0);
    cnt = 0;
    repeat (TO + 10) begin
      @(negedge clk);
      if (tx_valid) cnt++;
    end
    m_bump_err();
    check("t5_notx", 32'(cnt), 32'd0);
    check_outputs("t5_to");
    do_frame("t5_next", 8'h03, 24'd777, 8'h00, 0);

    // random frames against the model
    for (int k = 0; k < 60; k++) begin
      r  = $urandom_range(0, 9);
      v  = 24'($urandom_range(0, (1 << NB) - 1));
      cx = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      case (r)
        6: a = 8'h10;
        7: a = 8'h11;
        8: a = 8'($urandom_range(8'h20, 8'h7F));
        9: begin a = 8'($urandom_range(0, 5)); v = v | 24'h100000 << $urandom_range(0, 3); end
        default: a = 8'(r);
      endcase
      do_frame($sformatf("rnd%0d", k), a, v, cx, 0);
      pulse_boundary();
      check_outputs($sformatf("rnd%0d_b", k));
    end

    // 6a: response held by tx_ready=0, second response dropped but its write applies
    tx_ready = 1'b0;
    do_frame("t6_a", 8'h03, 24'd1234, 8'h00, 0);
    check("t6_a_txv", 32'(tx_valid), 32'd1);
    check("t6_a_txd", 32'(tx_data), 32'h06);
    do_frame("t6_b", 8'h04, 24'd999, 8'h00, 1);
    check("t6_b_txv", 32'(tx_valid), 32'd1);
    check("t6_b_txd", 32'(tx_data), 32'h06);
    tx_ready = 1'b1;
    @(negedge clk);
    check("t6_drop_txv", 32'(tx_valid), 32'd0);
    do_frame("t6_w0", 8'h00, 24'd1000, 8'h00, 0);
    do_frame("t6_cm", 8'h10, 24'd0, 8'h00, 0);
    pulse_boundary();
    check_outputs("t6_side");

    // error counter saturation
    for (int k = 0; k < 260; k++)
      do_frame($sformatf("sat%0d", k), 8'h7E, 24'd0, 8'h00, 0);
    check("err_sat", 32'(err_count), 32'd255);

    // 6b: async reset mid-frame with a held response
    tx_ready = 1'b0;
    do_frame("t6_c", 8'h02, 24'd42, 8'h00, 0);
    send_byte(8'hA5, 1);
    send_byte(8'h01, 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    check_outputs("t6_rst");
    check("t6_rst_txv", 32'(tx_valid), 32'd0);
    check("t6_rst_txd", 32'(tx_data), 32'd0);
    @(negedge clk);
    reset_n  = 1'b1;
    tx_ready = 1'b1;
    do_frame("t6_post_w", 8'h00, 24'd77, 8'h00, 0);
    do_frame("t6_post_cm", 8'h10, 24'd0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
